thor2022_bitfield_pipe: RTL and testbench

THOR2022_BITFIELD_PIPE -- requirements
Module: thor2022_bitfield_pipe

---
 rtl/thor2022_bitfield_pipe.sv | 157 +++++++++++++++
 tb/tb_thor2022_bitfield_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/thor2022_bitfield_pipe.sv
// Two-stage bit-field unit: mask/rotate-mask generation, field clear/set/
// change, signed/unsigned extract, insert and find-first-one in a field.
// Stage 1 captures the mask and the pre-shifted operands; stage 2 forms
// and holds the result under a valid/ready handshake on both sides.
module thor2022_bitfield_pipe #(
  parameter int WID  = 64,
  parameter int TAGW = 6,
  localparam int PW  = $clog2(WID)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [WID-1:0]  a_i,
  input  logic [WID-1:0]  ins_i,
  input  logic [PW-1:0]   mb_i,
  input  logic [PW-1:0]   me_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [WID-1:0]  res_o,
  output logic [TAGW-1:0] tag_o
);

  localparam logic [2:0] OP_ANDM  = 3'd0;
  localparam logic [2:0] OP_BFCLR = 3'd1;
  localparam logic [2:0] OP_BFSET = 3'd2;
  localparam logic [2:0] OP_BFCHG = 3'd3;
  localparam logic [2:0] OP_BFEXTU = 3'd4;
  localparam logic [2:0] OP_BFEXT = 3'd5;
  localparam logic [2:0] OP_BFINS = 3'd6;
  localparam logic [2:0] OP_BFFFO = 3'd7;

  // Stage 1 state
  logic            s1_valid_reg;
  logic [WID-1:0]  mask_reg;
  logic [WID-1:0]  a_reg;
  logic [WID-1:0]  shr_reg;
  logic [WID-1:0]  insh_reg;
  logic [PW-1:0]   mb_reg;
  logic [PW-1:0]   mw_reg;
  logic [2:0]      op_reg;
  logic [TAGW-1:0] tag1_reg;

  // Stage 2 state
  logic            s2_valid_reg;
  logic [WID-1:0]  res_reg;
  logic [TAGW-1:0] tag2_reg;

  // Stage 1 combinational values
  logic [WID-1:0]        mask_next;
  logic [WID-1:0]        shr_next;
  logic [WID-1:0]        insh_next;
  logic signed [WID-1:0] a_sar;

  // Stage 2 combinational values
  logic [WID-1:0] low_mask;
  logic [WID-1:0] am;
  logic           ffo_found;
  logic [PW-1:0]  ffo_idx;
  logic [PW-1:0]  ffo_diff;
  logic [WID-1:0] result_next;
  logic           load2;

  // Stage 2 takes new data when empty or being drained; stage 1 moves with it.
  assign load2       = !s2_valid_reg || res_ready_i;
  assign req_ready_o = !s1_valid_reg || load2;

  assign res_valid_o = s2_valid_reg;
  assign res_o       = res_reg;
  assign tag_o       = tag2_reg;

  // Per-bit field masks: the (possibly wrapping) mb..me mask for stage 1 and
  // the low "bits 0..mw" mask used by the extract ops in stage 2.
  generate
    for (genvar gi = 0; gi < WID; gi++) begin : g_mask
      localparam logic [PW-1:0] POS = gi;
      assign mask_next[gi] = (POS >= mb_i) ^ (POS <= me_i) ^ (me_i >= mb_i);
      assign low_mask[gi]  = (POS <= mw_reg);
    end
  endgenerate

  // Pre-shift operands: arithmetic right shift only for the signed extract.
  always_comb begin
    a_sar     = $signed(a_i) >>> mb_i;
    shr_next  = (op_i == OP_BFEXT) ? $unsigned(a_sar) : (a_i >> mb_i);
    insh_next = ins_i << mb_i;
  end

  // Highest set bit of the masked operand; offset is taken modulo WID so a
  // wrap-around field yields the bit distance counted from mb.
  always_comb begin
    am        = a_reg & mask_reg;
    ffo_found = 1'b0;
    ffo_idx   = '0;
    for (int i = 0; i < WID; i++) begin
      if (am[i]) begin
        ffo_found = 1'b1;
        ffo_idx   = PW'(i);
      end
    end
    ffo_diff = ffo_idx - mb_reg;
  end

  // Final result selection for the op held in stage 1.
  always_comb begin
    result_next = '0;
    case (op_reg)
      OP_ANDM:   result_next = a_reg & mask_reg;
      OP_BFCLR:  result_next = a_reg & ~mask_reg;
      OP_BFSET:  result_next = a_reg | mask_reg;
      OP_BFCHG:  result_next = a_reg ^ mask_reg;
      OP_BFEXTU: result_next = shr_reg & low_mask;
      OP_BFEXT:  result_next = (shr_reg & low_mask) |
                               (shr_reg[mw_reg] ? ~low_mask : '0);
      OP_BFINS:  result_next = (a_reg & ~mask_reg) | (insh_reg & mask_reg);
      OP_BFFFO:  result_next = ffo_found ? WID'(ffo_diff) : '1;
      default:   result_next = '0;
    endcase
  end

  // Stage 1 register: accept a request whenever the stage is free to move.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_reg <= 1'b0;
    end else if (req_ready_o) begin
      s1_valid_reg <= req_valid_i;
      if (req_valid_i) begin
        mask_reg <= mask_next;
        a_reg    <= a_i;
        shr_reg  <= shr_next;
        insh_reg <= insh_next;
        mb_reg   <= mb_i;
        mw_reg   <= me_i;
        op_reg   <= op_i;
        tag1_reg <= tag_i;
      end
    end
  end

  // Stage 2 register: result and tag hold while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_reg <= 1'b0;
      res_reg      <= '0;
      tag2_reg     <= '0;
    end else if (load2) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        res_reg  <= result_next;
        tag2_reg <= tag1_reg;
      end
    end
  end

endmodule

// File: tb/tb_thor2022_bitfield_pipe.sv
// Self-checking bench for thor2022_bitfield_pipe: directed vectors, a
// stall/ordering scenario, randomized traffic against a bit-level model,
// and reset with operations in flight.
module tb_thor2022_bitfield_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] ins;
  logic [5:0]  mb;
  logic [5:0]  me;
  logic [5:0]  tag;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res;
  logic [5:0]  tag_out;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  logic [63:0] exp_res_q[$];
  logic [5:0]  exp_tag_q[$];

  bit          hold_pending = 1'b0;
  logic [63:0] held_res;
  logic [5:0]  held_tag;
  bit          last_acc;
  bit          seen_valid;

  always #5 clk = ~clk;

  thor2022_bitfield_pipe #(.WID(64), .TAGW(6)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .a_i(a), .ins_i(ins), .mb_i(mb), .me_i(me), .tag_i(tag),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_o(res), .tag_o(tag_out)
  );

  task automatic check_val(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model evaluated bit by bit from the field definitions.
  function automatic logic [63:0] model(input logic [2:0] f_op, input logic [63:0] f_a,
                                        input logic [63:0] f_ins, input int f_mb, input int f_me);
    logic [63:0] m, sh, am, r;
    int hi;
    for (int n = 0; n < 64; n++)
      m[n] = (n >= f_mb) ^ (n <= f_me) ^ (f_me >= f_mb);
    for (int n = 0; n < 64; n++) begin
      if (n + f_mb < 64) sh[n] = f_a[n + f_mb];
      else               sh[n] = (f_op == 3'd5) ? f_a[63] : 1'b0;
    end
    r = '0;
    case (f_op)
      3'd0: r = f_a & m;
      3'd1: r = f_a & ~m;
      3'd2: r = f_a | m;
      3'd3: r = f_a ^ m;
      3'd4, 3'd5: begin
        r = sh;
        for (int n = f_me + 1; n < 64; n++) r[n] = (f_op == 3'd5) ? sh[f_me] : 1'b0;
      end
      3'd6: r = (f_a & ~m) | ((f_ins << f_mb) & m);
      default: begin
        am = f_a & m;
        hi = -1;
        for (int n = 0; n < 64; n++) if (am[n]) hi = n;
        if (hi < 0) r = '1;
        else        r = 64'((hi - f_mb + 64) % 64);
      end
    endcase
    return r;
  endfunction

  // One clock cycle: drive just after the edge, score at the falling edge.
  task automatic cyc(input bit v, input logic [2:0] c_op, input logic [63:0] c_a,
                     input logic [63:0] c_ins, input logic [5:0] c_mb, input logic [5:0] c_me,
                     input logic [5:0] c_tag, input bit rr);
    @(posedge clk);
    #1;
    req_valid = v; op = c_op; a = c_a; ins = c_ins; mb = c_mb; me = c_me;
    tag = c_tag; res_ready = rr;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      if (hold_pending) begin
        check_val("hold_valid", 64'(res_valid), 64'd1);
        check_val("hold_res", res, held_res);
        check_val("hold_tag", 64'(tag_out), 64'(held_tag));
        hold_pending = 1'b0;
      end
      if (res_valid && !res_ready) begin
        hold_pending = 1'b1;
        held_res = res;
        held_tag = tag_out;
      end
      if (res_valid && res_ready) begin
        n_pop++;
        if (exp_res_q.size() == 0) begin
          check_val("unexpected_result", 64'(tag_out), 64'h1_0000);
        end else begin
          check_val("order_tag", 64'(tag_out), 64'(exp_tag_q.pop_front()));
          check_val("result", res, exp_res_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        last_acc = 1'b1;
        exp_res_q.push_back(model(op, a, ins, int'(mb), int'(me)));
        exp_tag_q.push_back(tag);
      end
    end
  endtask

  task automatic idle(input bit rr);
    cyc(1'b0, 3'd0, 64'd0, 64'd0, 6'd0, 6'd0, 6'd0, rr);
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 20 && exp_res_q.size() != 0; k++) idle(1'b1);
    check_val(nm, 64'(exp_res_q.size()), 64'd0);
  endtask

  // Issue a single op with no backpressure and check the fixed 2-cycle latency.
  task automatic directed(input string nm, input logic [2:0] d_op, input logic [63:0] d_a,
                          input logic [63:0] d_ins, input logic [5:0] d_mb,
                          input logic [5:0] d_me, input logic [63:0] want);
    cyc(1'b1, d_op, d_a, d_ins, d_mb, d_me, 6'd9, 1'b1);
    idle(1'b1);
    check_val({nm, "_early"}, 64'(res_valid), 64'd0);
    idle(1'b1);
    check_val({nm, "_valid"}, 64'(res_valid), 64'd1);
    check_val(nm, res, want);
    drain({nm, "_drain"});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    op = '0; a = '0; ins = '0; mb = '0; me = '0; tag = '0;
    repeat (3) idle(1'b0);
    check_val("rst_res_valid", 64'(res_valid), 64'd0);
    check_val("rst_res", res, 64'd0);
    check_val("rst_tag", 64'(tag_out), 64'd0);
    rst = 1'b0;
    idle(1'b0);
    check_val("ready_after_rst", 64'(req_ready), 64'd1);

    directed("andm",  3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6'd4, 6'd11, 64'h0000_0000_0000_0FF0);
    directed("bfset_wrap", 3'd2, 64'd0, 64'd0, 6'd60, 6'd3, 64'hF000_0000_0000_000F);
    directed("bfext", 3'd5, 64'h8000, 64'd0, 6'd8, 6'd7, 64'hFFFF_FFFF_FFFF_FF80);
    directed("bfextu", 3'd4, 64'h8000, 64'd0, 6'd8, 6'd7, 64'h0000_0000_0000_0080);
    directed("bfins", 3'd6, 64'h0000_0000_FFFF_FFFF, 64'h12, 6'd8, 6'd15, 64'h0000_0000_FFFF_12FF);
    directed("bfffo", 3'd7, 64'h100, 64'd0, 6'd4, 6'd15, 64'd4);
    directed("bfffo_none", 3'd7, 64'h1, 64'd0, 6'd4, 6'd15, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back tags 1,2,3 into a stalled consumer.
    n_pop = 0;
    cyc(1'b1, 3'd0, 64'h11, 64'd0, 6'd0, 6'd7, 6'd1, 1'b0);
    cyc(1'b1, 3'd2, 64'h22, 64'd0, 6'd8, 6'd9, 6'd2, 1'b0);
    cyc(1'b1, 3'd3, 64'h33, 64'd0, 6'd1, 6'd2, 6'd3, 1'b0);
    check_val("stall_ready", 64'(req_ready), 64'd0);
    check_val("stall_head_tag", 64'(tag_out), 64'd1);
    cyc(1'b1, 3'd3, 64'h33, 64'd0, 6'd1, 6'd2, 6'd3, 1'b0);
    check_val("stall_ready2", 64'(req_ready), 64'd0);
    cyc(1'b1, 3'd3, 64'h33, 64'd0, 6'd1, 6'd2, 6'd3, 1'b1);
    check_val("stall_accept3", 64'(last_acc), 64'd1);
    drain("stall_drain");
    check_val("stall_count", 64'(n_pop), 64'd3);

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 600; k++) begin
      logic [63:0] ra;
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) ra = ra & {$urandom, $urandom} & {$urandom, $urandom};
      cyc(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra,
          {$urandom, $urandom}, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
          6'(k), ($urandom_range(0, 2) != 0));
    end
    drain("rand_drain");

    // Full pipe with accept and drain in the same cycle sustains 1/cycle.
    n_pop = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
          6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'(k), 1'b1);
      check_val("stream_accept", 64'(last_acc), 64'd1);
    end
    drain("stream_drain");
    check_val("stream_count", 64'(n_pop), 64'd10);

    // Reset with two operations in flight.
    cyc(1'b1, 3'd0, 64'hAA, 64'd0, 6'd0, 6'd7, 6'd40, 1'b0);
    cyc(1'b1, 3'd0, 64'hBB, 64'd0, 6'd0, 6'd7, 6'd41, 1'b0);
    idle(1'b0);
    check_val("inflight_valid", 64'(res_valid), 64'd1);
    rst = 1'b1;
    exp_res_q.delete();
    exp_tag_q.delete();
    hold_pending = 1'b0;
    idle(1'b0);
    rst = 1'b0;
    check_val("rst_flush_valid", 64'(res_valid), 64'd0);
    seen_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle(1'b1);
      if (res_valid) seen_valid = 1'b1;
    end
    check_val("rst_no_ghost", 64'(seen_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
